// File: rtl/debug_seq.sv
// debug_seq: front-panel run/halt/step sequencer for the SC/MP LCDS debug logic.
// Debounces the INIT and HALT push switches, watches the CPU status byte at each
// address strobe for the halt flag, and decides when to request the debug
// monitor (DEBUG_n), hold the CPU (CONT) and pulse CPU reset (CPU_RST_n).
//
// Optional feature macro: DEBUG_SEQ_DEBOUNCE_EN
//   defined   : counter debouncer per switch (DB_CYCLES stable cycles).
//   undefined : synchronised switch level used directly, DB_CYCLES ignored.
//
// Ports:
//   clk              system clock
//   RST              synchronous active-high reset
//   init_sw          raw INIT push switch, 1 = pressed
//   halt_sw          raw HALT/STEP push switch, 1 = pressed
//   run_mode_toggle  1 = run, 0 = single-step
//   halt_inst_toggle 1 = stop when CPU status shows H
//   ADS_n            CPU address strobe (synchronous to clk)
//   data             CPU data bus; status byte while ADS_n low (bit7 H, bit4 I)
//   INDBG_n          low while the debug routine executes
//   CONT             CPU continue; 0 holds the CPU
//   DEBUG_n          debug-entry request, active low
//   CPU_RST_n        CPU reset, active low
//   state            current state, for LEDs
//   stop_err         sticky: a STOP_REQ timed out
module debug_seq #(
   parameter logic [15:0] DB_CYCLES    = 16'd50000,
   parameter logic [7:0]  RESET_CYCLES = 8'd64,
   parameter logic [11:0] STOP_TIMEOUT = 12'd1024
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       init_sw,
   input  logic       halt_sw,
   input  logic       run_mode_toggle,
   input  logic       halt_inst_toggle,
   input  logic       ADS_n,
   input  logic [7:0] data,
   input  logic       INDBG_n,
   output logic       CONT,
   output logic       DEBUG_n,
   output logic       CPU_RST_n,
   output logic [2:0] state,
   output logic       stop_err
);

   localparam int unsigned TMR_W = 12;
   localparam int unsigned DB_W  = 16;

   typedef enum logic [2:0] {
      S_INIT     = 3'd0,
      S_RUN      = 3'd1,
      S_STOP_REQ = 3'd2,
      S_IN_DEBUG = 3'd3,
      S_HALTED   = 3'd4,
      S_STEP     = 3'd5
   } state_t;

   // Switch front end: bit 0 = init, bit 1 = halt
   logic [1:0] sw_raw;
   logic [1:0] sync1;
   logic [1:0] sync2;
   logic [1:0] db_lvl;
   logic [1:0] db_prev;
   logic [1:0] press;
   logic       unused_bits;

   assign sw_raw = {halt_sw, init_sw};

   // Two-flop synchroniser and rising-edge press detector
   always_ff @(posedge clk) begin
      if (RST) begin
         sync1   <= '0;
         sync2   <= '0;
         db_prev <= '0;
         press   <= '0;
      end else begin
         sync1   <= sw_raw;
         sync2   <= sync1;
         db_prev <= db_lvl;
         press   <= db_lvl & ~db_prev;
      end
   end

`ifdef DEBUG_SEQ_DEBOUNCE_EN
   logic [DB_W-1:0] db_cnt [2];

   // Counter debouncer: any return to the accepted level restarts the count
   always_ff @(posedge clk) begin
      if (RST) begin
         db_lvl <= '0;
         for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (sync2[k] == db_lvl[k]) begin
               db_cnt[k] <= '0;
            end else if (db_cnt[k] == DB_CYCLES - DB_W'(1)) begin
               db_lvl[k] <= sync2[k];
               db_cnt[k] <= '0;
            end else begin
               db_cnt[k] <= db_cnt[k] + DB_W'(1);
            end
         end
      end
   end

   assign unused_bits = ^{data[6:5], data[3:0]};
`else
   assign db_lvl      = sync2;
   assign unused_bits = ^{data[6:5], data[3:0], DB_CYCLES};
`endif

   logic init_press;
   logic halt_press;
   assign init_press = press[0];
   assign halt_press = press[1];

   // Address-strobe falling edge; status bits captured on the same edge
   logic ads_d;
   logic ads_ev;
   logic h_q;
   logic i_q;

   always_ff @(posedge clk) begin
      if (RST) begin
         ads_d  <= 1'b1;
         ads_ev <= 1'b0;
         h_q    <= 1'b0;
         i_q    <= 1'b0;
      end else begin
         ads_d  <= ADS_n;
         ads_ev <= ads_d & ~ADS_n;
         if (ads_d & ~ADS_n) begin
            h_q <= data[7];
            i_q <= data[4];
         end
      end
   end

   state_t           st;
   state_t           nxt;
   logic             timeout;
   logic [TMR_W-1:0] tmr;
   logic [1:0]       fetch_cnt;

   // Next-state decision; init press overrides every other transition
   always_comb begin
      nxt     = st;
      timeout = 1'b0;
      case (st)
         S_INIT: begin
            if (tmr == TMR_W'(RESET_CYCLES) - TMR_W'(1))
               nxt = run_mode_toggle ? S_RUN : S_HALTED;
         end
         S_RUN: begin
            if (halt_press || !run_mode_toggle || (ads_ev && h_q && halt_inst_toggle))
               nxt = S_STOP_REQ;
         end
         S_STOP_REQ: begin
            if (!INDBG_n) begin
               nxt = S_IN_DEBUG;
            end else if (tmr == STOP_TIMEOUT - TMR_W'(1)) begin
               nxt     = S_HALTED;
               timeout = 1'b1;
            end
         end
         S_IN_DEBUG: begin
            if (INDBG_n) nxt = S_HALTED;
         end
         S_HALTED: begin
            if (halt_press) nxt = run_mode_toggle ? S_RUN : S_STEP;
         end
         S_STEP: begin
            // Second fetch strobe means one full instruction has executed
            if (ads_ev && i_q && fetch_cnt == 2'd1) nxt = S_STOP_REQ;
         end
         default: nxt = S_INIT;
      endcase
      if (init_press) begin
         nxt     = S_INIT;
         timeout = 1'b0;
      end
   end

   // State, counters and outputs; outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (RST) begin
         st        <= S_INIT;
         tmr       <= '0;
         fetch_cnt <= '0;
         CONT      <= 1'b0;
         DEBUG_n   <= 1'b1;
         CPU_RST_n <= 1'b0;
         stop_err  <= 1'b0;
      end else begin
         st <= nxt;

         if (nxt != st || init_press)
            tmr <= '0;
         else if (st == S_INIT || st == S_STOP_REQ)
            tmr <= tmr + TMR_W'(1);

         if (nxt != st || init_press)
            fetch_cnt <= '0;
         else if (st == S_STEP && ads_ev && i_q)
            fetch_cnt <= fetch_cnt + 2'd1;

         if (init_press)
            stop_err <= 1'b0;
         else if (timeout)
            stop_err <= 1'b1;

         CONT      <= (nxt != S_INIT) && (nxt != S_HALTED);
         DEBUG_n   <= (nxt != S_STOP_REQ);
         CPU_RST_n <= (nxt != S_INIT);
      end
   end

   assign state = st;

endmodule

// File: tb/tb_debug_seq.sv
// Directed bench for debug_seq with DB_CYCLES = 4.
module tb_debug_seq;

`ifdef DEBUG_SEQ_DEBOUNCE_EN
   localparam int LAT = 8;
`else
   localparam int LAT = 4;
`endif

   logic       clk;
   logic       RST;
   logic       init_sw;
   logic       halt_sw;
   logic       run_mode_toggle;
   logic       halt_inst_toggle;
   logic       ADS_n;
   logic [7:0] data;
   logic       INDBG_n;
   logic       CONT;
   logic       DEBUG_n;
   logic       CPU_RST_n;
   logic [2:0] state;
   logic       stop_err;

   int checks;
   int errors;

   debug_seq #(
      .DB_CYCLES   (16'd4),
      .RESET_CYCLES(8'd64),
      .STOP_TIMEOUT(12'd1024)
   ) dut (
      .clk             (clk),
      .RST             (RST),
      .init_sw         (init_sw),
      .halt_sw         (halt_sw),
      .run_mode_toggle (run_mode_toggle),
      .halt_inst_toggle(halt_inst_toggle),
      .ADS_n           (ADS_n),
      .data            (data),
      .INDBG_n         (INDBG_n),
      .CONT            (CONT),
      .DEBUG_n         (DEBUG_n),
      .CPU_RST_n       (CPU_RST_n),
      .state           (state),
      .stop_err        (stop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      RST              = 1'b1;
      init_sw          = 1'b0;
      halt_sw          = 1'b0;
      run_mode_toggle  = 1'b1;
      halt_inst_toggle = 1'b0;
      ADS_n            = 1'b1;
      data             = 8'h00;
      INDBG_n          = 1'b1;

      // Reset values
      tick(3);
      chk("rst_state", 8'(state), 8'd0);
      chk("rst_cont", 8'(CONT), 8'd0);
      chk("rst_debug_n", 8'(DEBUG_n), 8'd1);
      chk("rst_cpu_rst_n", 8'(CPU_RST_n), 8'd0);
      chk("rst_stop_err", 8'(stop_err), 8'd0);

      // CPU reset pulse of 64 clocks, then RUN
      RST = 1'b0;
      tick(63);
      chk("init_hold_cpu_rst", 8'(CPU_RST_n), 8'd0);
      chk("init_hold_state", 8'(state), 8'd0);
      tick(1);
      chk("init_exit_state", 8'(state), 8'd1);
      chk("init_exit_cont", 8'(CONT), 8'd1);
      chk("init_exit_cpu_rst", 8'(CPU_RST_n), 8'd1);

      // H flag at address strobe stops the CPU two clocks after the fall
      halt_inst_toggle = 1'b1;
      ADS_n = 1'b0;
      data  = 8'h80;
      tick(1);
      ADS_n = 1'b1;
      chk("hflag_wait_debug_n", 8'(DEBUG_n), 8'd1);
      tick(1);
      chk("hflag_state", 8'(state), 8'd2);
      chk("hflag_debug_n", 8'(DEBUG_n), 8'd0);
      chk("hflag_cont", 8'(CONT), 8'd1);
      INDBG_n = 1'b0;
      tick(1);
      chk("indbg_state", 8'(state), 8'd3);
      chk("indbg_debug_n", 8'(DEBUG_n), 8'd1);
      tick(19);
      chk("indbg_hold", 8'(state), 8'd3);
      INDBG_n = 1'b1;
      tick(1);
      chk("halted_state", 8'(state), 8'd4);
      chk("halted_cont", 8'(CONT), 8'd0);

      // Single step: halt press in step mode, two fetches then STOP_REQ
      run_mode_toggle = 1'b0;
      halt_sw = 1'b1;
      tick(LAT - 1);
      chk("step_press_wait", 8'(state), 8'd4);
      tick(1);
      chk("step_state", 8'(state), 8'd5);
      chk("step_cont", 8'(CONT), 8'd1);
      halt_sw = 1'b0;
      tick(LAT + 2);
      data  = 8'h10;
      ADS_n = 1'b0;
      tick(1);
      ADS_n = 1'b1;
      tick(1);
      chk("step_fetch1_state", 8'(state), 8'd5);
      chk("step_fetch1_cont", 8'(CONT), 8'd1);
      tick(3);
      ADS_n = 1'b0;
      tick(1);
      ADS_n = 1'b1;
      tick(1);
      chk("step_fetch2_state", 8'(state), 8'd2);
      chk("step_fetch2_debug_n", 8'(DEBUG_n), 8'd0);

      // STOP_REQ timeout after 1024 clocks sets stop_err
      tick(1023);
      chk("timeout_wait_state", 8'(state), 8'd2);
      chk("timeout_wait_err", 8'(stop_err), 8'd0);
      tick(1);
      chk("timeout_state", 8'(state), 8'd4);
      chk("timeout_err", 8'(stop_err), 8'd1);
      chk("timeout_debug_n", 8'(DEBUG_n), 8'd1);
      chk("timeout_cont", 8'(CONT), 8'd0);

      // Init press clears stop_err and restarts the reset pulse
      run_mode_toggle = 1'b1;
      init_sw = 1'b1;
      tick(LAT - 1);
      chk("initp_wait_state", 8'(state), 8'd4);
      chk("initp_wait_err", 8'(stop_err), 8'd1);
      tick(1);
      chk("initp_state", 8'(state), 8'd0);
      chk("initp_err", 8'(stop_err), 8'd0);
      chk("initp_cpu_rst", 8'(CPU_RST_n), 8'd0);
      init_sw = 1'b0;
      tick(63);
      chk("initp_hold", 8'(CPU_RST_n), 8'd0);
      tick(1);
      chk("initp_run", 8'(state), 8'd1);

      // Bouncing halt switch: toggles every 2 clocks, ends high
      for (int i = 0; i < 15; i++) begin
         halt_sw = (i % 2 == 0);
         tick(2);
      end
`ifdef DEBUG_SEQ_DEBOUNCE_EN
      chk("bounce_filtered", 8'(state), 8'd1);
      tick(5);
      chk("bounce_settle_wait", 8'(state), 8'd1);
      tick(1);
      chk("bounce_settled", 8'(state), 8'd2);
`else
      chk("bounce_first_edge", 8'(state), 8'd2);
`endif
      halt_sw = 1'b0;
      tick(LAT + 2);

      // Init press while in IN_DEBUG
      INDBG_n = 1'b0;
      tick(1);
      chk("dbg_state", 8'(state), 8'd3);
      init_sw = 1'b1;
      tick(LAT - 1);
      chk("dbg_initp_wait", 8'(state), 8'd3);
      tick(1);
      chk("dbg_initp_state", 8'(state), 8'd0);
      chk("dbg_initp_debug_n", 8'(DEBUG_n), 8'd1);
      chk("dbg_initp_cpu_rst", 8'(CPU_RST_n), 8'd0);
      init_sw = 1'b0;
      INDBG_n = 1'b1;
      tick(63);
      chk("dbg_initp_hold", 8'(CPU_RST_n), 8'd0);
      tick(1);
      chk("dbg_initp_release", 8'(CPU_RST_n), 8'd1);
      chk("dbg_initp_run", 8'(state), 8'd1);

      // run_mode_toggle low in RUN, then RST mid-operation releases DEBUG_n
      run_mode_toggle = 1'b0;
      tick(1);
      chk("mode_stop_state", 8'(state), 8'd2);
      chk("mode_stop_debug_n", 8'(DEBUG_n), 8'd0);
      RST = 1'b1;
      tick(1);
      chk("midrst_state", 8'(state), 8'd0);
      chk("midrst_debug_n", 8'(DEBUG_n), 8'd1);
      chk("midrst_cont", 8'(CONT), 8'd0);
      chk("midrst_cpu_rst", 8'(CPU_RST_n), 8'd0);
      RST = 1'b0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
